reset_sequencer: RTL

Staged reset release for the GM64 core, directly downstream of the `reset` block. It takes the board-level reset (the inverted `reset` output) and releases the subsystem resets in a fixed order: memory, then video, then I/O (CIAs/SID), then CPU. The memory stage waits on a memory-ready handshake, bounded by a timeout. In the running state it also services warm-reset requests that restart only the CPU and I/O.

---
 rtl/reset_pkg.sv | 31 +++
 rtl/reset_sequencer_stage_timer.sv | 42 ++++
 rtl/reset_sequencer.sv | 125 ++++++++++++
 3 files changed

// File: rtl/reset_pkg.sv
// Shared definitions for the GM64 staged reset sequencer: state type,
// default timing constants and the counter-width helper.
package reset_pkg;

    // Sequencer states, in the order they are visited during a cold start.
    typedef enum logic [2:0] {
        ST_HOLD     = 3'd0,
        ST_MEM_WAIT = 3'd1,
        ST_VIDEO    = 3'd2,
        ST_IO       = 3'd3,
        ST_RUN      = 3'd4,
        ST_WARM     = 3'd5
    } rst_seq_state_t;

    // Default timing in clock edges.
    localparam int RST_STAGE_DELAY = 1024;
    localparam int RST_MEM_TIMEOUT = 65535;
    localparam int RST_WARM_CYCLES = 64;

    // Width needed to hold the largest terminal count of any timed state.
    function automatic int rst_cnt_width(input int stageDelay,
                                         input int memTimeout,
                                         input int warmCycles);
        int largest;
        largest = stageDelay;
        if (memTimeout > largest) largest = memTimeout;
        if (warmCycles > largest) largest = warmCycles;
        return $clog2(largest + 1);
    endfunction

endpackage

// File: rtl/reset_sequencer_stage_timer.sv
// Shared stage timer. Counts edges spent in the current state and raises a
// registered done flag during the cycle whose closing edge is the terminal
// edge, so the FSM can leave on exactly the N-th edge without a comb path.
module stage_timer #(
    parameter int WIDTH = 16
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_clear,
    input  logic             i_enable,
    input  logic [WIDTH-1:0] i_terminal,
    output logic             o_done
);

    logic [WIDTH-1:0] r_count;
    logic             r_done;
    logic [WIDTH:0]   w_countNext;
    logic [WIDTH:0]   w_lastBeforeTerm;

    // One extra bit keeps the increment and the terminal-minus-one compare
    // free of wrap-around for any terminal value that fits the counter.
    assign w_countNext      = {1'b0, r_count} + (WIDTH+1)'(1);
    assign w_lastBeforeTerm = {1'b0, i_terminal} - (WIDTH+1)'(1);

    // Clear on every state change; done is pre-computed for the state being
    // entered, so a terminal count of 1 is already flagged on entry.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_count <= '0;
            r_done  <= 1'b0;
        end else if (i_clear) begin
            r_count <= '0;
            r_done  <= (i_terminal == WIDTH'(1));
        end else if (i_enable) begin
            r_count <= w_countNext[WIDTH-1:0];
            r_done  <= (w_countNext == w_lastBeforeTerm);
        end
    end

    assign o_done = r_done;

endmodule

// File: rtl/reset_sequencer.sv
// Staged reset release for the GM64 core: memory, video, I/O, then CPU.
// Also handles warm resets that restart only the CPU and I/O while running.
module reset_sequencer
    import reset_pkg::*;
#(
    parameter int STAGE_DELAY = RST_STAGE_DELAY,
    parameter int MEM_TIMEOUT = RST_MEM_TIMEOUT,
    parameter int WARM_CYCLES = RST_WARM_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic mem_ready,
    input  logic warm_req,
    output logic rst_mem_n,
    output logic rst_video_n,
    output logic rst_io_n,
    output logic rst_cpu_n,
    output logic sys_running,
    output logic mem_timeout
);

    localparam int CNT_W = rst_cnt_width(STAGE_DELAY, MEM_TIMEOUT, WARM_CYCLES);

    rst_seq_state_t   r_state;
    rst_seq_state_t   w_nextState;
    logic             w_timerDone;
    logic             w_timerClear;
    logic             w_timerEnable;
    logic [CNT_W-1:0] w_terminal;
    logic             w_memTimedOut;

    logic             r_rstMemN;
    logic             r_rstVideoN;
    logic             r_rstIoN;
    logic             r_rstCpuN;
    logic             r_sysRunning;
    logic             r_memTimeout;

    // Next-state decision; reset is handled in the register block so it
    // overrides everything here, including a pending warm request.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_HOLD:     w_nextState = ST_MEM_WAIT;
            ST_MEM_WAIT: if (mem_ready || w_timerDone) w_nextState = ST_VIDEO;
            ST_VIDEO:    if (w_timerDone) w_nextState = ST_IO;
            ST_IO:       if (w_timerDone) w_nextState = ST_RUN;
            ST_RUN:      if (warm_req) w_nextState = ST_WARM;
            ST_WARM:     if (w_timerDone) w_nextState = ST_RUN;
            default:     w_nextState = ST_HOLD;
        endcase
    end

    // Terminal count for the state being entered or stayed in; untimed
    // states use zero so the timer never flags done there.
    always_comb begin
        w_terminal = '0;
        case (w_nextState)
            ST_MEM_WAIT: w_terminal = CNT_W'(MEM_TIMEOUT);
            ST_VIDEO:    w_terminal = CNT_W'(STAGE_DELAY);
            ST_IO:       w_terminal = CNT_W'(STAGE_DELAY);
            ST_WARM:     w_terminal = CNT_W'(WARM_CYCLES);
            default:     w_terminal = '0;
        endcase
    end

    // The timer restarts on any state change and only counts in timed states.
    always_comb begin
        w_timerClear  = (w_nextState != r_state);
        w_timerEnable = 1'b0;
        if (!w_timerClear) begin
            case (r_state)
                ST_MEM_WAIT, ST_VIDEO, ST_IO, ST_WARM: w_timerEnable = 1'b1;
                default:                               w_timerEnable = 1'b0;
            endcase
        end
    end

    // A timeout only counts when memory did not report ready on the same edge.
    assign w_memTimedOut = (r_state == ST_MEM_WAIT) && !mem_ready && w_timerDone;

    stage_timer #(
        .WIDTH(CNT_W)
    ) u_stageTimer (
        .i_clk      (clk),
        .i_reset    (reset),
        .i_clear    (w_timerClear),
        .i_enable   (w_timerEnable),
        .i_terminal (w_terminal),
        .o_done     (w_timerDone)
    );

    // State and output registers; outputs are decoded from the next state so
    // they change on the same edge as the state while staying registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_HOLD;
            r_rstMemN    <= 1'b0;
            r_rstVideoN  <= 1'b0;
            r_rstIoN     <= 1'b0;
            r_rstCpuN    <= 1'b0;
            r_sysRunning <= 1'b0;
            r_memTimeout <= 1'b0;
        end else begin
            r_state      <= w_nextState;
            r_rstMemN    <= (w_nextState != ST_HOLD);
            r_rstVideoN  <= (w_nextState == ST_VIDEO) || (w_nextState == ST_IO) ||
                            (w_nextState == ST_RUN)   || (w_nextState == ST_WARM);
            r_rstIoN     <= (w_nextState == ST_IO) || (w_nextState == ST_RUN);
            r_rstCpuN    <= (w_nextState == ST_RUN);
            r_sysRunning <= (w_nextState == ST_RUN);
            if (w_memTimedOut) begin
                r_memTimeout <= 1'b1;
            end
        end
    end

    assign rst_mem_n   = r_rstMemN;
    assign rst_video_n = r_rstVideoN;
    assign rst_io_n    = r_rstIoN;
    assign rst_cpu_n   = r_rstCpuN;
    assign sys_running = r_sysRunning;
    assign mem_timeout = r_memTimeout;

endmodule
